// File: rtl/eth_tx_sched.sv
// Round-robin scheduler sharing one 10BASE-T transmitter among NREQ sources.
// Times each frame from its length (preamble, data, CRC) and enforces the IPG.
module eth_tx_sched #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned LEN_W      = 11,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned MAX_LEN    = 1514,
  parameter int unsigned IPG_CYCLES = 192
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*LEN_W-1:0]     req_len,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [NREQ-1:0]           err_len,
  output logic                      start,
  output logic [LEN_W-1:0]          tx_len,
  output logic [$clog2(NREQ)-1:0]   tx_sel,
  output logic                      busy
);

  localparam int unsigned     SEL_W    = $clog2(NREQ);
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [15:0]     IPG_LOAD = 16'(IPG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    TX,
    GAP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [15:0]      cnt;
  logic             cnt_zero;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] idx;
  logic             win_valid;
  logic [LEN_W-1:0] win_len;
  logic             win_bad;
  logic [LEN_W-1:0] eff_len;
  logic [15:0]      tx_load;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] w);
    return (32'(w) == NREQ - 1) ? '0 : w + 1'b1;
  endfunction

  // First requester found scanning upward from ptr, wrapping mod NREQ.
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = SEL_W'((32'(ptr) + i) % NREQ);
      if (!win_valid && req[idx]) begin
        win       = idx;
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    win_len = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == SEL_W'(i)) begin
        win_len = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign win_bad  = (win_len > MAX_L);
  assign eff_len  = (win_len < MIN_L) ? MIN_L : win_len;
  assign cnt_zero = (cnt == '0);

  // D = 16*(8+len)+64 cycles of grant; START consumes one, TX ends on cnt==0.
  assign tx_load = (((16'(tx_len) + 16'd8) << 4) + 16'd64) - 16'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (win_valid && !win_bad) state_next = START;
      START: state_next = TX;
      TX:    if (cnt_zero) state_next = GAP;
      GAP:   if (cnt_zero) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt   = '0;
    start = (state == START);
    busy  = (state != IDLE);
    if (state == START || state == TX) begin
      gnt[tx_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      ptr     <= '0;
      tx_sel  <= '0;
      tx_len  <= '0;
      done    <= '0;
      err_len <= '0;
    end else begin
      done    <= '0;
      err_len <= '0;
      unique case (state)
        IDLE: begin
          if (win_valid) begin
            if (win_bad) begin
              err_len[win] <= 1'b1;
              ptr          <= wrap_inc(win);
            end else begin
              tx_sel <= win;
              tx_len <= eff_len;
            end
          end
        end
        START: cnt <= tx_load;
        TX: begin
          if (cnt_zero) begin
            done[tx_sel] <= 1'b1;
            cnt          <= IPG_LOAD;
            ptr          <= wrap_inc(tx_sel);
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        GAP: begin
          if (!cnt_zero) begin
            cnt <= cnt - 16'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
